// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared opcodes, flag indices and lock state type for the ALU arbiter
package alu_arb_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_MUL  = 3'b010;
    localparam logic [2:0] ALU_ACC  = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_PROM = 3'b110;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker returning a one-hot grant
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);

    // Search upward from the pointer, wrapping at NREQ; first set request wins.
    always_comb begin
        int  idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter with lock that shares one ALU among NREQ requesters
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int BITS     = 32,
    parameter int NREQ     = 4,
    parameter int LOCK_MAX = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_lock,
    input  logic [NREQ*BITS-1:0] req_srca,
    input  logic [NREQ*BITS-1:0] req_srcb,
    input  logic [NREQ*3-1:0]    req_ctrl,
    output logic [NREQ-1:0]      req_ready,
    output logic [BITS-1:0]      alu_srca,
    output logic [BITS-1:0]      alu_srcb,
    output logic [2:0]           alu_ctrl,
    input  logic [BITS-1:0]      alu_result,
    input  logic [3:0]           alu_flags,
    output logic [NREQ-1:0]      resp_valid,
    output logic [BITS-1:0]      resp_result,
    output logic [3:0]           resp_flags,
    output logic [NREQ-1:0]      lock_owner
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(LOCK_MAX + 1);

    lock_state_t     state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] owner_q, owner_d;
    logic            issue_v_q, issue_v_d;
    logic [PW-1:0]   issue_id_q, issue_id_d;
    logic [BITS-1:0] alu_srca_q, alu_srca_d;
    logic [BITS-1:0] alu_srcb_q, alu_srcb_d;
    logic [2:0]      alu_ctrl_q, alu_ctrl_d;
    logic [NREQ-1:0] resp_valid_q, resp_valid_d;
    logic [BITS-1:0] resp_result_q, resp_result_d;
    logic [3:0]      resp_flags_q, resp_flags_d;

    logic [NREQ-1:0] rr_grant;
    logic [NREQ-1:0] grant;
    logic            accept;
    logic [PW-1:0]   win_id;
    logic            win_lock;
    logic [BITS-1:0] win_srca;
    logic [BITS-1:0] win_srcb;
    logic [2:0]      win_ctrl;
    logic [CW-1:0]   cnt_inc;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (rr_grant)
    );

    // Grant selection: nothing while stalled or in reset; only the owner while locked.
    always_comb begin
        grant = '0;
        if (reset && !stall) begin
            if (state_q == UNLOCKED) begin
                grant = rr_grant;
            end else begin
                grant = owner_q & req_valid;
            end
        end
    end

    assign accept    = |grant;
    assign req_ready = grant;

    // Mux the winning requester's id, lock request and operands out of the packed buses.
    always_comb begin
        win_id   = '0;
        win_lock = 1'b0;
        win_srca = '0;
        win_srcb = '0;
        win_ctrl = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_id   = PW'(i);
                win_lock = req_lock[i];
                win_srca = req_srca[i*BITS +: BITS];
                win_srcb = req_srcb[i*BITS +: BITS];
                win_ctrl = req_ctrl[i*3 +: 3];
            end
        end
    end

    // Issue stage and pointer: capture the winner; operands hold when nothing is granted.
    always_comb begin
        ptr_d      = ptr_q;
        issue_v_d  = accept;
        issue_id_d = issue_id_q;
        alu_srca_d = alu_srca_q;
        alu_srcb_d = alu_srcb_q;
        alu_ctrl_d = alu_ctrl_q;
        if (accept) begin
            issue_id_d = win_id;
            alu_srca_d = win_srca;
            alu_srcb_d = win_srcb;
            alu_ctrl_d = win_ctrl;
            if (win_id == PW'(NREQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = win_id + 1'b1;
            end
        end
    end

    // Response stage: one cycle after issue, return the ALU result to the issuing requester.
    always_comb begin
        resp_valid_d  = '0;
        resp_result_d = resp_result_q;
        resp_flags_d  = resp_flags_q;
        if (issue_v_q) begin
            resp_valid_d  = NREQ'(1) << issue_id_q;
            resp_result_d = alu_result;
            resp_flags_d  = alu_flags;
        end
    end

    // Lock FSM: owner accept keeps or drops the lock; idle owner times out after LOCK_MAX cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        cnt_inc = (cnt_q == CW'(LOCK_MAX)) ? cnt_q : cnt_q + 1'b1;
        case (state_q)
            UNLOCKED: begin
                if (accept && win_lock) begin
                    state_d = LOCKED;
                    owner_d = grant;
                    cnt_d   = '0;
                end
            end
            LOCKED: begin
                // While locked, any accept is necessarily the owner's.
                if (accept) begin
                    cnt_d = '0;
                    if (!win_lock) begin
                        state_d = UNLOCKED;
                        owner_d = '0;
                    end
                end else if (cnt_inc == CW'(LOCK_MAX)) begin
                    state_d = UNLOCKED;
                    owner_d = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = UNLOCKED;
                owner_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; asynchronous reset discards any in-flight issue or response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= UNLOCKED;
            ptr_q         <= '0;
            cnt_q         <= '0;
            owner_q       <= '0;
            issue_v_q     <= 1'b0;
            issue_id_q    <= '0;
            alu_srca_q    <= '0;
            alu_srcb_q    <= '0;
            alu_ctrl_q    <= '0;
            resp_valid_q  <= '0;
            resp_result_q <= '0;
            resp_flags_q  <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            owner_q       <= owner_d;
            issue_v_q     <= issue_v_d;
            issue_id_q    <= issue_id_d;
            alu_srca_q    <= alu_srca_d;
            alu_srcb_q    <= alu_srcb_d;
            alu_ctrl_q    <= alu_ctrl_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_flags_q  <= resp_flags_d;
        end
    end

    assign alu_srca    = alu_srca_q;
    assign alu_srcb    = alu_srcb_q;
    assign alu_ctrl    = alu_ctrl_q;
    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign resp_flags  = resp_flags_q;
    assign lock_owner  = owner_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - table-driven self-checking bench for alu_arbiter
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int BITS     = 32;
    localparam int NREQ     = 4;
    localparam int LOCK_MAX = 15;

    logic                 clk;
    logic                 reset;
    logic                 stall;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_lock;
    logic [NREQ*BITS-1:0] req_srca;
    logic [NREQ*BITS-1:0] req_srcb;
    logic [NREQ*3-1:0]    req_ctrl;
    logic [NREQ-1:0]      req_ready;
    logic [BITS-1:0]      alu_srca;
    logic [BITS-1:0]      alu_srcb;
    logic [2:0]           alu_ctrl;
    logic [BITS-1:0]      alu_result;
    logic [3:0]           alu_flags;
    logic [NREQ-1:0]      resp_valid;
    logic [BITS-1:0]      resp_result;
    logic [3:0]           resp_flags;
    logic [NREQ-1:0]      lock_owner;

    int errors = 0;
    int checks = 0;

    alu_arbiter #(
        .BITS     (BITS),
        .NREQ     (NREQ),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .req_valid   (req_valid),
        .req_lock    (req_lock),
        .req_srca    (req_srca),
        .req_srcb    (req_srcb),
        .req_ctrl    (req_ctrl),
        .req_ready   (req_ready),
        .alu_srca    (alu_srca),
        .alu_srcb    (alu_srcb),
        .alu_ctrl    (alu_ctrl),
        .alu_result  (alu_result),
        .alu_flags   (alu_flags),
        .resp_valid  (resp_valid),
        .resp_result (resp_result),
        .resp_flags  (resp_flags),
        .lock_owner  (lock_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in combinational ALU driven by the arbiter's issue registers.
    always_comb begin
        logic [32:0] wide;
        logic        c;
        logic        v;
        wide = '0;
        c    = 1'b0;
        v    = 1'b0;
        case (alu_ctrl)
            ALU_ADD: begin
                wide = {1'b0, alu_srca} + {1'b0, alu_srcb};
                c    = wide[32];
                v    = (alu_srca[31] == alu_srcb[31]) && (wide[31] != alu_srca[31]);
            end
            ALU_SUB: begin
                wide = {1'b0, alu_srca} + {1'b0, ~alu_srcb} + 33'd1;
                c    = wide[32];
                v    = (alu_srca[31] != alu_srcb[31]) && (wide[31] != alu_srca[31]);
            end
            ALU_MUL:  wide = {1'b0, alu_srca * alu_srcb};
            ALU_ACC:  wide = {1'b0, alu_srca + alu_srcb};
            ALU_AND:  wide = {1'b0, alu_srca & alu_srcb};
            ALU_OR:   wide = {1'b0, alu_srca | alu_srcb};
            ALU_PROM: wide = {1'b0, alu_srca};
            default:  wide = '0;
        endcase
        alu_result         = wide[31:0];
        alu_flags          = '0;
        alu_flags[FLAG_N]  = wide[31];
        alu_flags[FLAG_Z]  = (wide[31:0] == 32'd0);
        alu_flags[FLAG_C]  = c;
        alu_flags[FLAG_V]  = v;
    end

    typedef struct {
        logic        stall;
        logic [3:0]  valid;
        logic [3:0]  lock;
        logic [11:0] ctrl;
        logic [3:0]  exp_ready;
        logic [3:0]  exp_rv;
        logic [31:0] exp_res;
        logic [3:0]  exp_flags;
        logic [3:0]  exp_owner;
    } vec_t;

    vec_t tbl [0:21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        req_srca[i*BITS +: BITS] = a;
        req_srcb[i*BITS +: BITS] = b;
    endtask

    task automatic run_rows(input int first, input int last);
        for (int r = first; r <= last; r++) begin
            @(negedge clk);
            stall     = tbl[r].stall;
            req_valid = tbl[r].valid;
            req_lock  = tbl[r].lock;
            req_ctrl  = tbl[r].ctrl;
            #1;
            chk($sformatf("row%0d ready", r), 32'(req_ready), 32'(tbl[r].exp_ready));
            chk($sformatf("row%0d resp_valid", r), 32'(resp_valid), 32'(tbl[r].exp_rv));
            chk($sformatf("row%0d lock_owner", r), 32'(lock_owner), 32'(tbl[r].exp_owner));
            if (tbl[r].exp_rv != 4'b0000) begin
                chk($sformatf("row%0d resp_result", r), resp_result, tbl[r].exp_res);
                chk($sformatf("row%0d resp_flags", r), 32'(resp_flags), 32'(tbl[r].exp_flags));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // stall, valid, lock, ctrl, exp_ready, exp_rv, exp_res, exp_flags, exp_owner
        // Round robin, all SUB: (3-5) (10-4) (0-1) (9-9)
        tbl[0]  = '{1'b0, 4'b0000, 4'b0000, 12'h249, 4'b0000, 4'b0000, 32'h0,        4'b0000, 4'b0000};
        tbl[1]  = '{1'b0, 4'b1111, 4'b0000, 12'h249, 4'b0001, 4'b0000, 32'h0,        4'b0000, 4'b0000};
        tbl[2]  = '{1'b0, 4'b1111, 4'b0000, 12'h249, 4'b0010, 4'b0000, 32'h0,        4'b0000, 4'b0000};
        tbl[3]  = '{1'b0, 4'b1111, 4'b0000, 12'h249, 4'b0100, 4'b0001, 32'hFFFFFFFE, 4'b1000, 4'b0000};
        tbl[4]  = '{1'b0, 4'b1111, 4'b0000, 12'h249, 4'b1000, 4'b0010, 32'h00000006, 4'b0010, 4'b0000};
        tbl[5]  = '{1'b0, 4'b1111, 4'b0000, 12'h249, 4'b0001, 4'b0100, 32'hFFFFFFFF, 4'b1000, 4'b0000};
        tbl[6]  = '{1'b0, 4'b0000, 4'b0000, 12'h249, 4'b0000, 4'b1000, 32'h00000000, 4'b0110, 4'b0000};
        tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 12'h249, 4'b0000, 4'b0001, 32'hFFFFFFFE, 4'b1000, 4'b0000};
        tbl[8]  = '{1'b0, 4'b0000, 4'b0000, 12'h249, 4'b0000, 4'b0000, 32'h0,        4'b0000, 4'b0000};
        // Single op: req0 ADD 5+7
        tbl[9]  = '{1'b0, 4'b0001, 4'b0000, 12'h248, 4'b0001, 4'b0000, 32'h0,        4'b0000, 4'b0000};
        tbl[10] = '{1'b0, 4'b0000, 4'b0000, 12'h248, 4'b0000, 4'b0000, 32'h0,        4'b0000, 4'b0000};
        tbl[11] = '{1'b0, 4'b0000, 4'b0000, 12'h248, 4'b0000, 4'b0001, 32'd12,       4'b0000, 4'b0000};
        // Stall with op in flight: req0 MUL 6*7
        tbl[12] = '{1'b0, 4'b0001, 4'b0000, 12'h24A, 4'b0001, 4'b0000, 32'h0,        4'b0000, 4'b0000};
        tbl[13] = '{1'b1, 4'b0001, 4'b0000, 12'h24A, 4'b0000, 4'b0000, 32'h0,        4'b0000, 4'b0000};
        tbl[14] = '{1'b0, 4'b0000, 4'b0000, 12'h24A, 4'b0000, 4'b0001, 32'd42,       4'b0000, 4'b0000};
        // Lock: req1 AND moves pointer to 2, then req2 ACC(lock) ACC(lock) PROM(unlock)
        tbl[15] = '{1'b0, 4'b0010, 4'b0000, 12'h0E5, 4'b0010, 4'b0000, 32'h0,        4'b0000, 4'b0000};
        tbl[16] = '{1'b0, 4'b0111, 4'b0100, 12'h0E5, 4'b0100, 4'b0000, 32'h0,        4'b0000, 4'b0000};
        tbl[17] = '{1'b0, 4'b0111, 4'b0100, 12'h0E5, 4'b0100, 4'b0010, 32'h0000000F, 4'b0000, 4'b0100};
        tbl[18] = '{1'b0, 4'b0111, 4'b0000, 12'h1A5, 4'b0100, 4'b0100, 32'd101,      4'b0000, 4'b0100};
        tbl[19] = '{1'b0, 4'b0111, 4'b0000, 12'h0E5, 4'b0001, 4'b0100, 32'd101,      4'b0000, 4'b0000};
        tbl[20] = '{1'b0, 4'b0000, 4'b0000, 12'h0E5, 4'b0000, 4'b0100, 32'd100,      4'b0000, 4'b0000};
        tbl[21] = '{1'b0, 4'b0000, 4'b0000, 12'h0E5, 4'b0000, 4'b0001, 32'h000000FF, 4'b0000, 4'b0000};

        reset     = 1'b0;
        stall     = 1'b0;
        req_valid = '0;
        req_lock  = '0;
        req_srca  = '0;
        req_srcb  = '0;
        req_ctrl  = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset resp_valid", 32'(resp_valid), 32'h0);
        chk("reset alu_srca", alu_srca, 32'h0);
        chk("reset lock_owner", 32'(lock_owner), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        set_ops(0, 32'd3, 32'd5);
        set_ops(1, 32'd10, 32'd4);
        set_ops(2, 32'd0, 32'd1);
        set_ops(3, 32'd9, 32'd9);
        run_rows(0, 8);

        set_ops(0, 32'd5, 32'd7);
        run_rows(9, 9);
        @(posedge clk);
        #1;
        chk("single alu_ctrl", 32'(alu_ctrl), 32'(ALU_ADD));
        chk("single alu_srca", alu_srca, 32'd5);
        chk("single alu_srcb", alu_srcb, 32'd7);
        run_rows(10, 11);

        set_ops(0, 32'd6, 32'd7);
        run_rows(12, 13);
        chk("stall alu_ctrl hold", 32'(alu_ctrl), 32'(ALU_MUL));
        run_rows(14, 14);

        set_ops(0, 32'h000000F0, 32'h0000000F);
        set_ops(1, 32'h000000FF, 32'h0000000F);
        set_ops(2, 32'd100, 32'd1);
        run_rows(15, 21);

        // Lock timeout: req1 locks then goes idle while req3 waits.
        @(negedge clk);
        req_ctrl  = {ALU_ADD, ALU_ADD, ALU_AND, ALU_OR};
        req_valid = 4'b0010;
        req_lock  = 4'b0010;
        #1;
        chk("timeout lock grant", 32'(req_ready), 32'b0010);
        for (int j = 1; j <= LOCK_MAX; j++) begin
            @(negedge clk);
            req_valid = 4'b1000;
            req_lock  = 4'b0000;
            stall     = (j == 5);
            #1;
            chk($sformatf("timeout wait%0d ready", j), 32'(req_ready), 32'h0);
            chk($sformatf("timeout wait%0d owner", j), 32'(lock_owner), 32'b0010);
        end
        @(negedge clk);
        stall = 1'b0;
        #1;
        chk("timeout req3 grant", 32'(req_ready), 32'b1000);
        chk("timeout owner cleared", 32'(lock_owner), 32'h0);

        // Reset mid-op: pointer is 0 after req3, so req0 wins; reset lands one cycle later.
        @(negedge clk);
        set_ops(0, 32'h11, 32'h22);
        req_valid = 4'b0001;
        #1;
        chk("midreset accept", 32'(req_ready), 32'b0001);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset ready", 32'(req_ready), 32'h0);
        chk("midreset alu_srca", alu_srca, 32'h0);
        chk("midreset alu_srcb", alu_srcb, 32'h0);
        chk("midreset alu_ctrl", 32'(alu_ctrl), 32'h0);
        chk("midreset resp_valid", 32'(resp_valid), 32'h0);
        chk("midreset resp_result", resp_result, 32'h0);
        chk("midreset resp_flags", 32'(resp_flags), 32'h0);
        chk("midreset lock_owner", 32'(lock_owner), 32'h0);
        @(negedge clk);
        req_valid = 4'b0000;
        reset     = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            #1;
            chk($sformatf("postreset%0d resp_valid", j), 32'(resp_valid), 32'h0);
        end
        @(negedge clk);
        req_valid = 4'b0011;
        #1;
        chk("postreset pointer", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = 4'b0000;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single combinational 32-bit ALU between NREQ requesters, for example the pipeline execute stage and the averaging/accumulate engines. Requests are arbitrated round-robin, and the winner's operands and opcode are registered into an issue stage. The ALU result and flags are registered into a response stage and returned to the winning requester. An optional per-requester lock keeps a multi-op sequence (e.g. ACC chain, then PROM) on the ALU without interleaving.

Parameters:
BITS, 32, datapath width; must match the ALU BITS.
NREQ, 4, number of requesters (2..8).
LOCK_MAX, 15, idle cycles after which a held lock auto-releases.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
stall  in  1  1 = grant nothing this cycle.
req_valid  in  NREQ  request strobe per requester.
req_lock  in  NREQ  with req_valid: keep ownership after this op.
req_srca  in  NREQ*BITS  operand A; requester i occupies bits [i*BITS +: BITS].
req_srcb  in  NREQ*BITS  operand B, same packing.
req_ctrl  in  NREQ*3  ALU opcode, requester i occupies bits [i*3 +: 3].
req_ready  out  NREQ  one-hot grant, combinational; op accepted at the edge where valid&ready.
alu_srca  out  BITS  registered operand A to the ALU.
alu_srcb  out  BITS  registered operand B to the ALU.
alu_ctrl  out  3  registered opcode to the ALU.
alu_result  in  BITS  ALU result.
alu_flags  in  4  ALU flags {N,Z,C,V}.
resp_valid  out  NREQ  one-hot, one-cycle response strobe.
resp_result  out  BITS  registered result.
resp_flags  out  4  registered flags.
lock_owner  out  NREQ  one-hot current lock holder; 0 when unlocked.

Behaviour:
- Reset (reset low, asynchronous): all outputs 0; rr pointer=0; state=UNLOCKED; lock counter=0; issue and response stages invalid.
- Arbitration, combinational:
  - stall=1 -> req_ready=0.
  - UNLOCKED: grant the first set req_valid bit searching from the pointer upward, wrapping at NREQ.
  - LOCKED: grant only the owner, only when the owner's req_valid=1.
- Accept edge, when any grant is given:
  - alu_srca/srcb/ctrl <= winner's fields.
  - issue_id <= winner; issue_v <= 1.
  - Pointer <= (winner+1) mod NREQ.
- No grant at an edge: issue_v <= 0, and alu_* hold their previous values.
- Response edge, one cycle after accept: if issue_v, then resp_result <= alu_result, resp_flags <= alu_flags, resp_valid <= onehot(issue_id). Otherwise resp_valid <= 0.
- Latency: accept at edge k, resp_valid high for exactly the cycle after edge k+1.
- Throughput is one op per cycle. There is no response backpressure; requesters must sample resp_valid.
- stall does not cancel an in-flight op; the issued op still responds.
- Lock state machine:
  - UNLOCKED -> LOCKED when accepted with req_lock=1. lock_owner <= winner, counter <= 0.
  - LOCKED -> LOCKED when the owner is accepted with req_lock=1. counter <= 0.
  - LOCKED -> UNLOCKED when the owner is accepted with req_lock=0. The op issues normally, then the lock drops.
  - LOCKED -> UNLOCKED when the counter reaches LOCK_MAX without an owner accept. Other requesters become eligible the next cycle.
  - Counter increments each LOCKED cycle without an owner accept, including stalled cycles. Saturates at LOCK_MAX.
- Simultaneous events:
  - Owner accept and timeout in the same cycle: the accept wins and the counter is cleared.
  - Pointer still advances past the owner, so fairness resumes after release.
- Reset mid-operation: in-flight issue and response are discarded; no resp_valid is produced after reset deassertion.
- No width conversion: result and flags pass through unmodified. Opcode 3'b111 is forwarded as-is.

Decomposition:
- Package alu_arb_pkg contains:
  - Opcode constants: ALU_ADD=000, ALU_SUB=001, ALU_MUL=010, ALU_ACC=011, ALU_AND=100, ALU_OR=101, ALU_PROM=110.
  - Flag indices: FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - lock_state_t enum {UNLOCKED, LOCKED}.
- Sub-module rr_pick (NREQ): takes the request vector and pointer, returns a one-hot grant. It is purely combinational and unit-tested separately.

Test Plan:
- Single op: req0 ADD A=5, B=7 -> req_ready[0]=1 same cycle; alu_ctrl=000 after the edge; resp_valid=0001, resp_result=12, flags=0000 two edges after accept.
- Round-robin: all 4 requesters valid continuously from pointer 0 -> grants in order 0,1,2,3,0; each resp_result matches its own SUB (e.g. 3-5 -> 0xFFFFFFFE, N=1).
- Lock: req2 issues ACC with lock=1, then ACC, then PROM with lock=0, while req0 and req1 stay valid -> req2 gets 3 consecutive grants; req0 is granted the cycle after the PROM accept; lock_owner=0100 until then.
- Lock timeout: req1 locks, then drops valid; req3 valid -> req3 granted exactly LOCK_MAX+1 cycles later and lock_owner returns to 0.
- Stall with op in flight: accept req0 MUL 6*7, assert stall the next cycle -> resp_result=42 still delivered on schedule; no req_ready while stall=1.
- Reset mid-op: assert reset the cycle after accept -> all outputs 0 immediately; no resp_valid after release; pointer=0.
